ospfb_frame_capture: RTL and testbench
======================================

OSPFB_FRAME_CAPTURE -- requirements
Module: ospfb_frame_capture

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning tdata width ({im,re} of 16-bit parts).
REQ-002 SHALL have parameter FFT_LEN, default 64, meaning beats per frame and channel index range.
REQ-003 SHALL have parameter NFRAMES, default 4, meaning frames captured per arm.
REQ-004 SHALL have parameter ADDR_WID, default $clog2(FFT_LEN*NFRAMES), meaning buffer address width.
REQ-005 SHALL have port clk, input, 1, meaning the single clock for all logic.
REQ-006 SHALL have port rstn, input, 1, meaning reset: asynchronous, active-low.
REQ-007 SHALL have port s_axis, axis.SLV (WIDTH), meaning the OSPFB output data stream (tdata/tvalid/tready).
REQ-008 SHALL have port s_axis_tlast, input, 1, meaning last channel of frame.
REQ-009 SHALL have port s_axis_tuser, input, 8, meaning channel index.
REQ-010 SHALL have port arm, input, 1, meaning single-cycle capture start.
REQ-011 SHALL have port clear, input, 1, meaning synchronous return to IDLE and clearing of errors.
REQ-012 SHALL have port rd_addr, input, ADDR_WID, meaning buffer read address.
REQ-013 SHALL have port rd_data, output, WIDTH, meaning buffer read data.
REQ-014 SHALL have port full, output, 1, meaning NFRAMES frames captured.
REQ-015 SHALL have port frame_cnt, output, $clog2(NFRAMES+1), meaning completed frames.
REQ-016 SHALL have ports err_tlast_early, err_tlast_missing and err_seq, outputs, 1 each, meaning sticky framing errors.

Function
REQ-017 SHALL implement states IDLE, ARMED, CAPTURE, DONE; a beat is s_axis.tvalid & s_axis.tready.
REQ-018 SHALL drive s_axis.tready=1 in IDLE/ARMED/CAPTURE and 0 in DONE; beats accepted in IDLE are discarded.
REQ-019 SHALL move IDLE->ARMED on arm; arm outside IDLE is ignored.
REQ-020 SHALL, in ARMED, discard beats until a beat with tuser==0, then write that beat to address 0 and go to CAPTURE.
REQ-021 SHALL, in CAPTURE, write each beat's tdata at wr_addr, then increment wr_addr.
REQ-022 SHALL keep expected index idx (0..FFT_LEN-1), advancing per captured beat and wrapping FFT_LEN-1->0.
REQ-023 SHALL set err_seq when a captured beat has tuser!=idx; idx continues to advance (no resync on tuser).
REQ-024 SHALL set err_tlast_early on tlast with idx!=FFT_LEN-1, then force idx to 0; frame_cnt is not incremented.
REQ-025 SHALL set err_tlast_missing on idx==FFT_LEN-1 without tlast; the frame still counts.
REQ-026 SHALL increment frame_cnt on each captured beat with idx==FFT_LEN-1.
REQ-027 SHALL go to DONE and assert full on the cycle after the beat that makes frame_cnt==NFRAMES.
REQ-028 SHALL have wr_addr saturate; no write occurs outside ARMED/CAPTURE.
REQ-029 SHALL have rd_data registered: data for rd_addr appears one cycle later.
REQ-030 SHALL give read-during-write to the same address the old data.
REQ-031 SHALL, on clear in any state, go to IDLE and zero idx, wr_addr, frame_cnt, full and errors next cycle.
REQ-032 SHALL give clear priority over arm when both are asserted.
REQ-033 SHALL preserve buffer contents on clear.

Reset
REQ-034 SHALL, while rstn=0, force state IDLE and zero full, frame_cnt, errors, idx and wr_addr, with tready=1 and rd_data=0.
REQ-035 SHALL leave buffer contents unreset.
REQ-036 SHALL, on reset mid-CAPTURE, abandon the capture; the next capture requires a new arm.

Structure
REQ-037 SHALL place the state enum typedef (cap_state_t) in the shared package ospfb_pkg.
REQ-038 SHALL implement the buffer as sub-module sdp_ram (simple dual-port, 1 write, 1 registered read, parameters WIDTH/DEPTH).

Verification
REQ-039 SHALL verify: arm, then 4 clean frames (tuser 0..63, tlast at 63, tdata=beat number 0..255) -> full=1 one cycle after beat 255, frame_cnt=4, no errors, rd_addr=70 -> rd_data=70 next cycle.
REQ-040 SHALL verify: arm while stream is at tuser=20 -> beats 20..63 discarded; address 0 holds the next tuser=0 beat.
REQ-041 SHALL verify: tlast at tuser=31 -> err_tlast_early=1, frame_cnt unchanged, next beat treated as idx 0.
REQ-042 SHALL verify: no tlast at tuser=63 -> err_tlast_missing=1, frame_cnt increments; tuser 10 followed by 12 -> err_seq=1.
REQ-043 SHALL verify: while full, tready=0 held for 10 cycles; then clear -> IDLE, full=0, errors=0, buffer unchanged.
REQ-044 SHALL verify: rstn low after 100 captured beats -> all outputs at reset values; new arm recaptures from address 0.

Source files
------------

// File: rtl/ospfb_pkg.sv
// Shared types for the OSPFB frame capture block: capture state encoding and
// the channel-index sideband width.
package ospfb_pkg;

    typedef enum logic [1:0] {
        CAP_IDLE,
        CAP_ARMED,
        CAP_CAPTURE,
        CAP_DONE
    } cap_state_t;

    localparam int TUSER_WID = 8;

endpackage

// File: rtl/axis_if.sv
// Minimal AXI-Stream bundle (data, valid, ready); sideband signals travel as
// separate ports so each consumer picks only what it needs.
interface axis #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] tdata;
    logic             tvalid;
    logic             tready;

    modport SLV (input tdata, input tvalid, output tready);
    modport MST (output tdata, output tvalid, input tready);
endinterface

// File: rtl/sdp_ram.sv
// Simple dual-port RAM: one write port, one read port with registered output.
// A read of the address being written in the same cycle returns the old word.
module sdp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 256,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // NOTE: storage has no reset so it maps onto block RAM; only the output register resets.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rdata_o <= '0;
        end else begin
            rdata_o <= mem_q[raddr_i];
        end
    end

endmodule

// File: rtl/ospfb_frame_capture.sv
// Captures NFRAMES frames of OSPFB channel data into a buffer after an arm,
// aligning on channel 0 and flagging sticky framing errors along the way.
module ospfb_frame_capture
    import ospfb_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int FFT_LEN  = 64,
    parameter int NFRAMES  = 4,
    parameter int ADDR_WID = $clog2(FFT_LEN * NFRAMES)
) (
    input  logic                         clk,
    input  logic                         rstn,
    axis.SLV                             s_axis,
    input  logic                         s_axis_tlast,
    input  logic [TUSER_WID-1:0]         s_axis_tuser,
    input  logic                         arm,
    input  logic                         clear,
    input  logic [ADDR_WID-1:0]          rd_addr,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic [$clog2(NFRAMES+1)-1:0] frame_cnt,
    output logic                         err_tlast_early,
    output logic                         err_tlast_missing,
    output logic                         err_seq
);

    localparam int DEPTH   = FFT_LEN * NFRAMES;
    localparam int IDX_WID = $clog2(FFT_LEN);
    localparam int FC_WID  = $clog2(NFRAMES + 1);
    localparam logic [IDX_WID-1:0]  IDX_LAST  = IDX_WID'(FFT_LEN - 1);
    localparam logic [ADDR_WID-1:0] ADDR_LAST = ADDR_WID'(DEPTH - 1);

    cap_state_t          state_q, state_d;
    logic [IDX_WID-1:0]  idx_q, idx_d;
    logic [ADDR_WID-1:0] wr_addr_q, wr_addr_d;
    logic [FC_WID-1:0]   frame_cnt_q, frame_cnt_d;
    logic                full_q, full_d;
    logic                err_early_q, err_early_d;
    logic                err_missing_q, err_missing_d;
    logic                err_seq_q, err_seq_d;
    logic                tready;
    logic                beat;
    logic                capture;

    assign tready        = (state_q != CAP_DONE);
    assign s_axis.tready = tready;
    assign beat          = s_axis.tvalid & tready;

    // NOTE: every variable gets a default first so no path can infer a latch.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        wr_addr_d     = wr_addr_q;
        frame_cnt_d   = frame_cnt_q;
        full_d        = full_q;
        err_early_d   = err_early_q;
        err_missing_d = err_missing_q;
        err_seq_d     = err_seq_q;
        capture       = 1'b0;

        if (clear) begin
            state_d       = CAP_IDLE;
            idx_d         = '0;
            wr_addr_d     = '0;
            frame_cnt_d   = '0;
            full_d        = 1'b0;
            err_early_d   = 1'b0;
            err_missing_d = 1'b0;
            err_seq_d     = 1'b0;
        end else begin
            unique case (state_q)
                CAP_IDLE: begin
                    if (arm) begin
                        state_d     = CAP_ARMED;
                        idx_d       = '0;
                        wr_addr_d   = '0;
                        frame_cnt_d = '0;
                    end
                end
                CAP_ARMED: begin
                    if (beat && s_axis_tuser == '0) begin
                        capture = 1'b1;
                        state_d = CAP_CAPTURE;
                    end
                end
                CAP_CAPTURE: capture = beat;
                default: ;
            endcase

            if (capture) begin
                wr_addr_d = (wr_addr_q == ADDR_LAST) ? wr_addr_q : wr_addr_q + ADDR_WID'(1);
                if (s_axis_tuser != TUSER_WID'(idx_q)) begin
                    err_seq_d = 1'b1;
                end
                if (idx_q == IDX_LAST) begin
                    idx_d       = '0;
                    frame_cnt_d = frame_cnt_q + FC_WID'(1);
                    if (!s_axis_tlast) begin
                        err_missing_d = 1'b1;
                    end
                end else if (s_axis_tlast) begin
                    // Early tlast restarts the frame without counting it.
                    idx_d       = '0;
                    err_early_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_WID'(1);
                end
                if (frame_cnt_d == FC_WID'(NFRAMES)) begin
                    state_d = CAP_DONE;
                    full_d  = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= CAP_IDLE;
            idx_q         <= '0;
            wr_addr_q     <= '0;
            frame_cnt_q   <= '0;
            full_q        <= 1'b0;
            err_early_q   <= 1'b0;
            err_missing_q <= 1'b0;
            err_seq_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            wr_addr_q     <= wr_addr_d;
            frame_cnt_q   <= frame_cnt_d;
            full_q        <= full_d;
            err_early_q   <= err_early_d;
            err_missing_q <= err_missing_d;
            err_seq_q     <= err_seq_d;
        end
    end

    sdp_ram #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_buf (
        .clk     (clk),
        .rstn    (rstn),
        .we_i    (capture),
        .waddr_i (wr_addr_q),
        .wdata_i (s_axis.tdata),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign full              = full_q;
    assign frame_cnt         = frame_cnt_q;
    assign err_tlast_early   = err_early_q;
    assign err_tlast_missing = err_missing_q;
    assign err_seq           = err_seq_q;

endmodule

// File: tb/tb_ospfb_frame_capture.sv
// Directed bench for ospfb_frame_capture: clean capture, alignment on arm,
// framing errors, hold-off while full, clear and mid-capture reset.
module tb_ospfb_frame_capture;

    logic        clk = 1'b0;
    logic        rstn;
    logic        tlast;
    logic [7:0]  tuser;
    logic        arm;
    logic        clear;
    logic [7:0]  rd_addr;
    logic [31:0] rd_data;
    logic        full;
    logic [2:0]  frame_cnt;
    logic        err_early;
    logic        err_missing;
    logic        err_seq;
    logic [31:0] got;

    int n_checks = 0;
    int n_errors = 0;

    axis #(.WIDTH(32)) s_axis_if ();

    ospfb_frame_capture #(
        .WIDTH   (32),
        .FFT_LEN (64),
        .NFRAMES (4)
    ) dut (
        .clk               (clk),
        .rstn              (rstn),
        .s_axis            (s_axis_if),
        .s_axis_tlast      (tlast),
        .s_axis_tuser      (tuser),
        .arm               (arm),
        .clear             (clear),
        .rd_addr           (rd_addr),
        .rd_data           (rd_data),
        .full              (full),
        .frame_cnt         (frame_cnt),
        .err_tlast_early   (err_early),
        .err_tlast_missing (err_missing),
        .err_seq           (err_seq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_checks++;
        if (got_v !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got_v, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] d, input int u, input logic last);
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = d;
        tuser            = 8'(u);
        tlast            = last;
        tick();
        s_axis_if.tvalid = 1'b0;
        tlast            = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic read_word(input logic [7:0] a, output logic [31:0] d);
        rd_addr = a;
        tick();
        d = rd_data;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " full"},      32'(full), 32'd0);
        check({tag, " frame_cnt"}, 32'(frame_cnt), 32'd0);
        check({tag, " errors"},    {29'd0, err_early, err_missing, err_seq}, 32'd0);
        check({tag, " tready"},    32'(s_axis_if.tready), 32'd1);
        check({tag, " rd_data"},   rd_data, 32'd0);
    endtask

    initial begin
        rstn             = 1'b0;
        s_axis_if.tvalid = 1'b0;
        s_axis_if.tdata  = '0;
        tuser            = '0;
        tlast            = 1'b0;
        arm              = 1'b0;
        clear            = 1'b0;
        rd_addr          = '0;
        repeat (3) tick();
        check_reset_outputs("reset");
        rstn = 1'b1;
        tick();

        // Four clean frames, tdata = beat number.
        pulse_arm();
        for (int i = 0; i < 256; i++) begin
            send_beat(32'(i), i % 64, (i % 64) == 63);
            if (i == 254) check("full before last beat", 32'(full), 32'd0);
        end
        check("full after beat 255", 32'(full), 32'd1);
        check("frame_cnt clean", 32'(frame_cnt), 32'd4);
        check("errors clean", {29'd0, err_early, err_missing, err_seq}, 32'd0);
        read_word(8'd70, got);
        check("rd addr 70", got, 32'd70);

        // Hold-off while full, then clear.
        s_axis_if.tvalid = 1'b1;
        s_axis_if.tdata  = 32'hDEAD;
        tuser            = '0;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("tready low while full", 32'(s_axis_if.tready), 32'd0);
        end
        check("frame_cnt held while full", 32'(frame_cnt), 32'd4);
        s_axis_if.tvalid = 1'b0;
        pulse_clear();
        check("full after clear", 32'(full), 32'd0);
        check("frame_cnt after clear", 32'(frame_cnt), 32'd0);
        check("tready after clear", 32'(s_axis_if.tready), 32'd1);
        read_word(8'd70, got);
        check("buffer kept 70", got, 32'd70);
        read_word(8'd255, got);
        check("buffer kept 255", got, 32'd255);

        // Arm mid-frame at tuser 20: capture aligns on the next channel 0.
        rd_addr = 8'd0;
        for (int i = 0; i < 128; i++) begin
            if (i == 20) arm = 1'b1;
            send_beat(32'h1000 + 32'(i), i % 64, (i % 64) == 63);
            arm = 1'b0;
            if (i == 63) check("no count before align", 32'(frame_cnt), 32'd0);
            if (i == 64) check("read during write old", rd_data, 32'd0);
            if (i == 65) check("addr0 new data", rd_data, 32'h1040);
        end
        check("aligned frame_cnt", 32'(frame_cnt), 32'd1);
        check("aligned errors", {29'd0, err_early, err_missing, err_seq}, 32'd0);
        read_word(8'd63, got);
        check("aligned addr 63", got, 32'h107F);

        // Early tlast at tuser 31, then a clean frame restarting at channel 0.
        for (int u = 0; u < 32; u++) send_beat(32'h4000 + 32'(u), u, u == 31);
        check("early tlast flag", 32'(err_early), 32'd1);
        check("early frame_cnt", 32'(frame_cnt), 32'd1);
        for (int u = 0; u < 64; u++) send_beat(32'h5000 + 32'(u), u, u == 63);
        check("seq ok after early", 32'(err_seq), 32'd0);
        check("missing ok after early", 32'(err_missing), 32'd0);
        check("frame_cnt after early", 32'(frame_cnt), 32'd2);
        read_word(8'd96, got);
        check("restart beat addr 96", got, 32'h5000);
        pulse_clear();
        check("early cleared", 32'(err_early), 32'd0);

        // Missing tlast, then a skipped channel index.
        pulse_arm();
        for (int u = 0; u < 64; u++) send_beat(32'h6000 + 32'(u), u, 1'b0);
        check("missing tlast flag", 32'(err_missing), 32'd1);
        check("missing frame_cnt", 32'(frame_cnt), 32'd1);
        check("missing early clear", 32'(err_early), 32'd0);
        for (int u = 0; u < 11; u++) send_beat(32'h7000 + 32'(u), u, 1'b0);
        check("seq before skip", 32'(err_seq), 32'd0);
        send_beat(32'h700C, 12, 1'b0);
        check("seq after skip", 32'(err_seq), 32'd1);
        pulse_clear();
        check("errors after clear", {29'd0, err_early, err_missing, err_seq}, 32'd0);

        // Reset after 100 captured beats; capture restarts only on a new arm.
        pulse_arm();
        for (int i = 0; i < 100; i++) send_beat(32'h2000 + 32'(i), i % 64, (i % 64) == 63);
        check("frame_cnt before reset", 32'(frame_cnt), 32'd1);
        rstn = 1'b0;
        #1;
        check_reset_outputs("mid reset");
        tick();
        rstn = 1'b1;
        send_beat(32'h3FFF, 0, 1'b0);
        read_word(8'd0, got);
        check("no capture without arm", got, 32'h2000);
        pulse_arm();
        for (int u = 0; u < 64; u++) send_beat(32'h3000 + 32'(u), u, u == 63);
        read_word(8'd0, got);
        check("recapture addr 0", got, 32'h3000);
        read_word(8'd1, got);
        check("recapture addr 1", got, 32'h3001);
        check("recapture frame_cnt", 32'(frame_cnt), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
